// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one combinational adder between N requesters.
// Optional macro ADDER_RR_ARBITER_CARRY_EN adds a registered carry-out port resp_carry.

module simple_adder_v #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef ADDER_RR_ARBITER_CARRY_EN
  output logic         carry,
`endif
  output logic [W-1:0] sum
);

`ifdef ADDER_RR_ARBITER_CARRY_EN
  assign {carry, sum} = a + b;
`else
  assign sum = a + b;
`endif

endmodule

module adder_rr_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N-1:0]                           req_valid,
  output logic [N-1:0]                           req_ready,
  input  logic [N*W-1:0]                         req_x_0,
  input  logic [N*W-1:0]                         req_x_1,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   resp_id,
`ifdef ADDER_RR_ARBITER_CARRY_EN
  output logic                                   resp_carry,
`endif
  output logic [W-1:0]                           resp_result
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] lat_id;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   sum;
`ifdef ADDER_RR_ARBITER_CARRY_EN
  logic           carry;
`endif

  simple_adder_v #(.W(W)) u_adder (
    .a     (op_a),
    .b     (op_b),
`ifdef ADDER_RR_ARBITER_CARRY_EN
    .carry (carry),
`endif
    .sum   (sum)
  );

  // Search starts just after the last served requester, so it gets lowest priority.
  always_comb begin : grant_search
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(last_grant) + 1 + k) % N;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(N - 1);
      lat_id      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
`ifdef ADDER_RR_ARBITER_CARRY_EN
      resp_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= req_x_0[int'(grant_idx)*W +: W];
            op_b   <= req_x_1[int'(grant_idx)*W +: W];
            lat_id <= grant_idx;
            state  <= CALC;
          end
        end
        CALC: begin
          resp_result <= sum;
`ifdef ADDER_RR_ARBITER_CARRY_EN
          resp_carry  <= carry;
`endif
          resp_id     <= lat_id;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (W=8, N=4).
// Carry checks are compiled only when ADDER_RR_ARBITER_CARRY_EN is defined.

module tb_adder_rr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x_0;
  logic [N*W-1:0] req_x_1;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_result;
`ifdef ADDER_RR_ARBITER_CARRY_EN
  logic           resp_carry;
`endif

  int checks;
  int failures;

  adder_rr_arbiter #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x_0     (req_x_0),
    .req_x_1     (req_x_1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
`ifdef ADDER_RR_ARBITER_CARRY_EN
    .resp_carry  (resp_carry),
`endif
    .resp_result (resp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*W-1:0] x0,
                               input logic [N*W-1:0] x1, input logic rdy);
    req_valid  = valid;
    req_x_0    = x0;
    req_x_1    = x1;
    resp_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [N*W-1:0] rr_x0;
  logic [N*W-1:0] rr_x1;
  logic [W-1:0]   rr_sum [N];
  int             rr_order [5];
  logic [N-1:0]   exp_ready;

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_x_0    = '0;
    req_x_1    = '0;
    resp_ready = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset_resp_result", 32'(resp_result), 32'h0);
    checkOutput("reset_resp_id", 32'(resp_id), 32'h0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);

    // Single request from requester 0: 0x12 + 0x34
    applyStimulus(4'b0001, {24'h0, 8'h12}, {24'h0, 8'h34}, 1'b1);
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000, '0, '0, 1'b1);
    checkOutput("single_calc_ready", 32'(req_ready), 32'h0);
    checkOutput("single_calc_valid", 32'(resp_valid), 32'h0);
    tick();
    checkOutput("single_valid", 32'(resp_valid), 32'h1);
    checkOutput("single_id", 32'(resp_id), 32'h0);
    checkOutput("single_result", 32'(resp_result), 32'h46);
    tick();
    checkOutput("single_valid_drop", 32'(resp_valid), 32'h0);

    // Round-robin with all four requesters continuously valid
    doReset();
    rr_x0     = {8'h40, 8'h30, 8'h20, 8'h10};
    rr_x1     = {8'h04, 8'h03, 8'h02, 8'h01};
    rr_sum[0] = 8'h11;
    rr_sum[1] = 8'h22;
    rr_sum[2] = 8'h33;
    rr_sum[3] = 8'h44;
    rr_order  = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, rr_x0, rr_x1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_ready = '0;
      exp_ready[rr_order[i]] = 1'b1;
      checkOutput($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(exp_ready));
      tick();
      tick();
      checkOutput($sformatf("rr%0d_valid", i), 32'(resp_valid), 32'h1);
      checkOutput($sformatf("rr%0d_id", i), 32'(resp_id), 32'(rr_order[i]));
      checkOutput($sformatf("rr%0d_result", i), 32'(resp_result), 32'(rr_sum[rr_order[i]]));
      tick();
    end

    // Wrap-around: 0xFF + 0x02 = 0x01 with carry out
    doReset();
    applyStimulus(4'b0001, {24'h0, 8'hFF}, {24'h0, 8'h02}, 1'b1);
    tick();
    applyStimulus(4'b0000, '0, '0, 1'b1);
    tick();
    checkOutput("wrap_valid", 32'(resp_valid), 32'h1);
    checkOutput("wrap_result", 32'(resp_result), 32'h01);
`ifdef ADDER_RR_ARBITER_CARRY_EN
    checkOutput("wrap_carry", 32'(resp_carry), 32'h1);
`endif
    tick();

    // Backpressure: requester 1 holds RESP for 5 cycles while requester 0 waits
    doReset();
    applyStimulus(4'b0010, {16'h0, 8'h55, 8'h0A}, {16'h0, 8'h22, 8'h0B}, 1'b0);
    checkOutput("bp_grant", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'b0011, {16'h0, 8'h99, 8'h0A}, {16'h0, 8'h99, 8'h0B}, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_valid", c), 32'(resp_valid), 32'h1);
      checkOutput($sformatf("bp%0d_id", c), 32'(resp_id), 32'h1);
      checkOutput($sformatf("bp%0d_result", c), 32'(resp_result), 32'h77);
      checkOutput($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    tick();
    checkOutput("bp_release_valid", 32'(resp_valid), 32'h0);
    checkOutput("bp_next_grant", 32'(req_ready), 32'h1);

    // Reset while in CALC discards the transaction
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstmid_valid", 32'(resp_valid), 32'h0);
    checkOutput("rstmid_result", 32'(resp_result), 32'h0);
    checkOutput("rstmid_grant0", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000, '0, '0, 1'b1);
    tick();
    checkOutput("rstmid_resp_id", 32'(resp_id), 32'h0);
    checkOutput("rstmid_resp_result", 32'(resp_result), 32'h15);
    tick();

    // Late withdraw: requester 2 gives up while requester 1 is in RESP
    doReset();
    applyStimulus(4'b0110, {8'h0, 8'h07, 8'h05, 8'h0}, {8'h0, 8'h07, 8'h06, 8'h0}, 1'b0);
    checkOutput("lw_grant1", 32'(req_ready), 32'h2);
    tick();
    tick();
    checkOutput("lw_result", 32'(resp_result), 32'h0B);
    applyStimulus(4'b0000, '0, '0, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("lw%0d_valid", c), 32'(resp_valid), 32'h0);
      checkOutput($sformatf("lw%0d_ready", c), 32'(req_ready), 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
